// File: rtl/dm_arbiter_if.sv
// Requester-side and data-memory-side signals of the dm_arbiter.
// The arbiter uses the slave view; the requesters and memory use the master view.
interface dm_arbiter_if;
    logic        req0, req1;
    logic        we0, we1;
    logic [1:0]  size0, size1;
    logic [31:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [31:0] pc0, pc1;
    logic        gnt0, gnt1;
    logic        rvalid0, rvalid1;
    logic [31:0] rdata;
    logic        err;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_pc;
    logic [1:0]  mem_size;
    logic [31:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, size0, size1, addr0, addr1,
               wdata0, wdata1, pc0, pc1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, err,
               mem_read, mem_write, mem_addr, mem_wdata, mem_pc, mem_size
    );

    modport master (
        output req0, req1, we0, we1, size0, size1, addr0, addr1,
               wdata0, wdata1, pc0, pc1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, err,
               mem_read, mem_write, mem_addr, mem_wdata, mem_pc, mem_size
    );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter/sequencer sharing the single-port data memory between the
// MEM stage (master 0) and the debug/DMA loader (master 1): IDLE -> ACCESS -> RESP.
module dm_arbiter #(
    parameter int unsigned ADDR_HI = 14
) (
    input  logic        clk,
    input  logic        reset,
    dm_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        id_q, id_d;
    logic        we_q, we_d;
    logic        bad_q, bad_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rdata_q, rdata_d;

    logic        win_valid, win;
    logic        sel_we;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr, sel_wdata, sel_pc;

    function automatic logic access_bad(input logic [1:0] size, input logic [31:0] addr);
        logic misaligned;
        logic out_of_range;
        misaligned   = (size == 2'd0 && addr[1:0] != 2'b00) || (size == 2'd1 && addr[0]);
        out_of_range = (addr >> ADDR_HI) != 32'd0;
        return (size == 2'd3) || misaligned || out_of_range;
    endfunction

    // last_q = 1 means master 1 held the previous grant, so master 0 wins a tie.
    always_comb begin
        win_valid = bus.req0 | bus.req1;
        win       = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
        sel_we    = win ? bus.we1    : bus.we0;
        sel_size  = win ? bus.size1  : bus.size0;
        sel_addr  = win ? bus.addr1  : bus.addr0;
        sel_wdata = win ? bus.wdata1 : bus.wdata0;
        sel_pc    = win ? bus.pc1    : bus.pc0;
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        id_d          = id_q;
        we_d          = we_q;
        bad_d         = bad_q;
        size_d        = size_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        pc_d          = pc_q;
        rdata_d       = rdata_q;
        bus.gnt0      = 1'b0;
        bus.gnt1      = 1'b0;
        bus.rvalid0   = 1'b0;
        bus.rvalid1   = 1'b0;
        bus.err       = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    bus.gnt0 = ~win;
                    bus.gnt1 = win;
                    id_d     = win;
                    last_d   = win;
                    we_d     = sel_we;
                    size_d   = sel_size;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    pc_d     = sel_pc;
                    bad_d    = access_bad(sel_size, sel_addr);
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                bus.mem_write = we_q & ~bad_q;
                bus.mem_read  = ~we_q & ~bad_q;
                // A rejected access never reaches the memory, so report zero data.
                rdata_d       = bad_q ? 32'd0 : bus.mem_rdata;
                state_d       = RESP;
            end
            RESP: begin
                bus.rvalid0 = ~id_q;
                bus.rvalid1 = id_q;
                bus.err     = bad_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments make every flop sample its pre-edge _d
    // value regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            pc_q    <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            we_q    <= we_d;
            bad_q   <= bad_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_pc    = pc_q;
    assign bus.mem_size  = size_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus randomized contention
// checked against a transaction-level model of arbitration and memory contents.
module tb_dm_arbiter;
    localparam int unsigned ADDR_HI    = 14;
    localparam logic [31:0] ADDR_LIMIT = 32'd1 << ADDR_HI;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dm_arbiter_if bus ();

    dm_arbiter #(.ADDR_HI(ADDR_HI)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic        p_req   [2];
    logic        p_we    [2];
    logic [1:0]  p_size  [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    logic [31:0] p_pc    [2];

    assign bus.req0   = p_req[0];
    assign bus.req1   = p_req[1];
    assign bus.we0    = p_we[0];
    assign bus.we1    = p_we[1];
    assign bus.size0  = p_size[0];
    assign bus.size1  = p_size[1];
    assign bus.addr0  = p_addr[0];
    assign bus.addr1  = p_addr[1];
    assign bus.wdata0 = p_wdata[0];
    assign bus.wdata1 = p_wdata[1];
    assign bus.pc0    = p_pc[0];
    assign bus.pc1    = p_pc[1];

    // Data memory: combinational read, posedge write with save_sel byte lanes.
    logic [31:0] dmem [0:4095] = '{default: 32'h0};
    assign bus.mem_rdata = dmem[bus.mem_addr[13:2]];
    always @(posedge clk) begin
        if (bus.mem_write) begin
            case (bus.mem_size)
                2'd0: dmem[bus.mem_addr[13:2]] <= bus.mem_wdata;
                2'd1: begin
                    if (bus.mem_addr[1]) dmem[bus.mem_addr[13:2]][31:16] <= bus.mem_wdata[15:0];
                    else                 dmem[bus.mem_addr[13:2]][15:0]  <= bus.mem_wdata[15:0];
                end
                2'd2: begin
                    case (bus.mem_addr[1:0])
                        2'd0: dmem[bus.mem_addr[13:2]][7:0]   <= bus.mem_wdata[7:0];
                        2'd1: dmem[bus.mem_addr[13:2]][15:8]  <= bus.mem_wdata[7:0];
                        2'd2: dmem[bus.mem_addr[13:2]][23:16] <= bus.mem_wdata[7:0];
                        default: dmem[bus.mem_addr[13:2]][31:24] <= bus.mem_wdata[7:0];
                    endcase
                end
                default: ;
            endcase
        end
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_last = 1;
    logic [31:0] ref_mem [0:4095];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int m, input logic we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
        p_req[m]   = 1'b1;
        p_we[m]    = we;
        p_size[m]  = sz;
        p_addr[m]  = a;
        p_wdata[m] = wd;
        p_pc[m]    = $urandom;
    endtask

    function automatic logic model_bad(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd0 && a % 4 != 0) ||
               (sz == 2'd1 && a % 2 != 0) || (a >= ADDR_LIMIT);
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] mask;
        int          sh;
        sh = 8 * int'(a % 4);
        case (sz)
            2'd0:    begin mask = 32'hFFFF_FFFF; sh = 0; end
            2'd1:    mask = 32'h0000_FFFF;
            2'd2:    mask = 32'h0000_00FF;
            default: mask = 32'h0;
        endcase
        return (old & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    // One full transaction from IDLE with the current p_* requests standing.
    task automatic arbitrate_once(output logic [31:0] got_rd, output logic got_err);
        int          w;
        logic        bad, we_s;
        logic [1:0]  sz_s;
        logic [31:0] a_s, wd_s, pc_s, exp_rd;
        #1;
        if (p_req[0] && p_req[1]) w = (exp_last == 1) ? 0 : 1;
        else if (p_req[0])        w = 0;
        else                      w = 1;
        n_checks++; if (bus.gnt0 !== (w == 0)) begin n_errors++; $display("FAIL gnt0: got %b want %b", bus.gnt0, (w == 0)); end
        n_checks++; if (bus.gnt1 !== (w == 1)) begin n_errors++; $display("FAIL gnt1: got %b want %b", bus.gnt1, (w == 1)); end
        we_s = p_we[w]; sz_s = p_size[w]; a_s = p_addr[w]; wd_s = p_wdata[w]; pc_s = p_pc[w];
        bad    = model_bad(sz_s, a_s);
        exp_rd = bad ? 32'd0 : ref_mem[(a_s / 4) % 4096];
        if (we_s && !bad) ref_mem[(a_s / 4) % 4096] = model_merge(exp_rd, wd_s, sz_s, a_s);
        exp_last = w;
        step();
        p_req[w] = 1'b0;
        n_checks++; if (bus.mem_write !== (we_s && !bad)) begin n_errors++; $display("FAIL mem_write: got %b want %b", bus.mem_write, (we_s && !bad)); end
        n_checks++; if (bus.mem_read !== (!we_s && !bad)) begin n_errors++; $display("FAIL mem_read: got %b want %b", bus.mem_read, (!we_s && !bad)); end
        n_checks++; if (bus.mem_addr !== a_s) begin n_errors++; $display("FAIL mem_addr: got %h want %h", bus.mem_addr, a_s); end
        n_checks++; if (bus.mem_size !== sz_s) begin n_errors++; $display("FAIL mem_size: got %0d want %0d", bus.mem_size, sz_s); end
        n_checks++; if (bus.mem_wdata !== wd_s) begin n_errors++; $display("FAIL mem_wdata: got %h want %h", bus.mem_wdata, wd_s); end
        n_checks++; if (bus.mem_pc !== pc_s) begin n_errors++; $display("FAIL mem_pc: got %h want %h", bus.mem_pc, pc_s); end
        n_checks++; if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1} !== 4'b0) begin n_errors++; $display("FAIL access_quiet: got gnt/rvalid %b want 0000", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1}); end
        step();
        n_checks++; if (bus.rvalid0 !== (w == 0)) begin n_errors++; $display("FAIL rvalid0: got %b want %b", bus.rvalid0, (w == 0)); end
        n_checks++; if (bus.rvalid1 !== (w == 1)) begin n_errors++; $display("FAIL rvalid1: got %b want %b", bus.rvalid1, (w == 1)); end
        n_checks++; if (bus.err !== bad) begin n_errors++; $display("FAIL err: got %b want %b (addr %h size %0d)", bus.err, bad, a_s, sz_s); end
        n_checks++; if (bus.rdata !== exp_rd) begin n_errors++; $display("FAIL rdata: got %h want %h (addr %h)", bus.rdata, exp_rd, a_s); end
        n_checks++; if ({bus.gnt0, bus.gnt1, bus.mem_read, bus.mem_write} !== 4'b0) begin n_errors++; $display("FAIL resp_quiet: got gnt/mem %b want 0000", {bus.gnt0, bus.gnt1, bus.mem_read, bus.mem_write}); end
        got_rd  = bus.rdata;
        got_err = bus.err;
        step();
        n_checks++; if ({bus.rvalid0, bus.rvalid1} !== 2'b00) begin n_errors++; $display("FAIL rvalid_idle: got %b want 00", {bus.rvalid0, bus.rvalid1}); end
    endtask

    task automatic test_reset();
        logic [6:0]   flags;
        logic [129:0] buses;
        logic [31:0]  rd;
        logic         er;
        for (int m = 0; m < 2; m++) begin
            p_req[m] = 1'b0; p_we[m] = 1'b0; p_size[m] = 2'd0;
            p_addr[m] = 32'd0; p_wdata[m] = 32'd0; p_pc[m] = 32'd0;
        end
        for (int i = 0; i < 4096; i++) ref_mem[i] = 32'd0;
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        #1;
        flags = {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err, bus.mem_read, bus.mem_write};
        buses = {bus.rdata, bus.mem_addr, bus.mem_wdata, bus.mem_pc, bus.mem_size};
        n_checks++; if (flags !== 7'b0) begin n_errors++; $display("FAIL reset_flags: got %b want 0", flags); end
        n_checks++; if (buses !== 130'b0) begin n_errors++; $display("FAIL reset_buses: got %h want 0", buses); end

        post(0, 1'b1, 2'd0, 32'h10, 32'hDEAD_BEEF);
        #1;
        n_checks++; if (bus.gnt0 !== 1'b1) begin n_errors++; $display("FAIL abort_gnt0: got %b want 1", bus.gnt0); end
        step();
        p_req[0] = 1'b0;
        n_checks++; if (bus.mem_write !== 1'b1) begin n_errors++; $display("FAIL abort_access: got mem_write %b want 1", bus.mem_write); end
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (bus.mem_write !== 1'b0) begin n_errors++; $display("FAIL abort_async: got mem_write %b want 0", bus.mem_write); end
        step();
        step();
        reset = 1'b1;
        #1;
        flags = {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err, bus.mem_read, bus.mem_write};
        buses = {bus.rdata, bus.mem_addr, bus.mem_wdata, bus.mem_pc, bus.mem_size};
        n_checks++; if (flags !== 7'b0) begin n_errors++; $display("FAIL abort_flags: got %b want 0", flags); end
        n_checks++; if (buses !== 130'b0) begin n_errors++; $display("FAIL abort_buses: got %h want 0", buses); end
        exp_last = 1;
        post(0, 1'b0, 2'd0, 32'h10, 32'd0);
        arbitrate_once(rd, er);
        n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL abort_readback: got %h want 00000000", rd); end
    endtask

    task automatic test_round_trip();
        logic [31:0] rd;
        logic        er;
        post(0, 1'b1, 2'd0, 32'h20, 32'h1234_5678);
        arbitrate_once(rd, er);
        n_checks++; if (er !== 1'b0) begin n_errors++; $display("FAIL sw_err: got %b want 0", er); end
        post(0, 1'b0, 2'd0, 32'h20, 32'd0);
        arbitrate_once(rd, er);
        n_checks++; if (rd !== 32'h1234_5678) begin n_errors++; $display("FAIL lw_roundtrip: got %h want 12345678", rd); end
    endtask

    task automatic test_subword();
        logic [31:0] rd;
        logic        er;
        post(1, 1'b1, 2'd2, 32'h21, 32'h0000_00AB);
        arbitrate_once(rd, er);
        post(0, 1'b0, 2'd0, 32'h20, 32'd0);
        arbitrate_once(rd, er);
        n_checks++; if (rd !== 32'h1234_AB78) begin n_errors++; $display("FAIL sb_merge: got %h want 1234ab78", rd); end
        post(1, 1'b1, 2'd1, 32'h22, 32'h0000_CDEF);
        arbitrate_once(rd, er);
        post(1, 1'b0, 2'd0, 32'h20, 32'd0);
        arbitrate_once(rd, er);
        n_checks++; if (rd !== 32'hCDEF_AB78) begin n_errors++; $display("FAIL sh_merge: got %h want cdefab78", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        post(1, 1'b1, 2'd0, 32'h0, 32'h5A5A_5A5A);
        arbitrate_once(rd, er);
        for (int k = 0; k < 4; k++) begin
            case (k)
                0:       post(0, 1'b1, 2'd0, 32'h22,   32'h1111_1111);
                1:       post(1, 1'b1, 2'd1, 32'h23,   32'h2222_2222);
                2:       post(0, 1'b1, 2'd3, 32'h20,   32'h3333_3333);
                default: post(1, 1'b0, 2'd0, 32'h4000, 32'd0);
            endcase
            arbitrate_once(rd, er);
            n_checks++; if (er !== 1'b1) begin n_errors++; $display("FAIL err_flag[%0d]: got %b want 1", k, er); end
            n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL err_rdata[%0d]: got %h want 00000000", k, rd); end
        end
        n_checks++; if (dmem[8] !== 32'hCDEF_AB78) begin n_errors++; $display("FAIL err_mem_intact: got %h want cdefab78", dmem[8]); end
        post(0, 1'b0, 2'd0, 32'h20, 32'd0);
        arbitrate_once(rd, er);
        n_checks++; if (rd !== 32'hCDEF_AB78) begin n_errors++; $display("FAIL err_readback: got %h want cdefab78", rd); end
    endtask

    task automatic test_tie();
        int w;
        reset = 1'b0;
        post(0, 1'b0, 2'd0, 32'h100, 32'd0);
        post(1, 1'b0, 2'd0, 32'h104, 32'd0);
        step();
        step();
        reset = 1'b1;
        for (int c = 0; c < 18; c++) begin
            if (c == 12) p_req[1] = 1'b0;
            #1;
            w = (c < 12) ? (c / 3) % 2 : 0;
            n_checks++; if (bus.gnt0 !== (c % 3 == 0 && w == 0)) begin n_errors++; $display("FAIL tie_gnt0 c%0d: got %b want %b", c, bus.gnt0, (c % 3 == 0 && w == 0)); end
            n_checks++; if (bus.gnt1 !== (c % 3 == 0 && w == 1)) begin n_errors++; $display("FAIL tie_gnt1 c%0d: got %b want %b", c, bus.gnt1, (c % 3 == 0 && w == 1)); end
            n_checks++; if (bus.rvalid0 !== (c % 3 == 2 && w == 0)) begin n_errors++; $display("FAIL tie_rvalid0 c%0d: got %b want %b", c, bus.rvalid0, (c % 3 == 2 && w == 0)); end
            n_checks++; if (bus.rvalid1 !== (c % 3 == 2 && w == 1)) begin n_errors++; $display("FAIL tie_rvalid1 c%0d: got %b want %b", c, bus.rvalid1, (c % 3 == 2 && w == 1)); end
            if (c == 17) p_req[0] = 1'b0;
            step();
        end
        exp_last = 0;
    endtask

    task automatic test_drop();
        logic [31:0] exp_rd;
        exp_rd = ref_mem[8];
        post(0, 1'b0, 2'd0, 32'h20, 32'd0);
        #1;
        n_checks++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin n_errors++; $display("FAIL drop_grant: got %b want 10", {bus.gnt0, bus.gnt1}); end
        step();
        p_req[0] = 1'b0;
        post(1, 1'b1, 2'd0, 32'h30, 32'h7777_7777);
        #1;
        n_checks++; if (bus.gnt1 !== 1'b0) begin n_errors++; $display("FAIL drop_gnt1_access: got %b want 0", bus.gnt1); end
        step();
        n_checks++; if ({bus.rvalid0, bus.rvalid1, bus.gnt1} !== 3'b100) begin n_errors++; $display("FAIL drop_resp: got rv0/rv1/gnt1 %b want 100", {bus.rvalid0, bus.rvalid1, bus.gnt1}); end
        n_checks++; if (bus.rdata !== exp_rd) begin n_errors++; $display("FAIL drop_rdata: got %h want %h", bus.rdata, exp_rd); end
        p_req[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++; if ({bus.gnt1, bus.rvalid1, bus.mem_write} !== 3'b000) begin n_errors++; $display("FAIL drop_idle c%0d: got gnt1/rv1/mem_write %b want 000", c, {bus.gnt1, bus.rvalid1, bus.mem_write}); end
        end
        n_checks++; if (dmem[12] !== ref_mem[12]) begin n_errors++; $display("FAIL drop_mem: got %h want %h", dmem[12], ref_mem[12]); end
        exp_last = 0;
    endtask

    task automatic rand_post(input int m);
        int          r;
        logic [1:0]  sz;
        logic [31:0] a;
        r  = $urandom_range(0, 15);
        sz = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
        a  = 32'h200 + $urandom_range(0, 63);
        if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd4 >> sz) - 32'd1);
        if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(ADDR_HI, 31));
        post(m, 1'($urandom_range(0, 1)), sz, a, $urandom);
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic        er;
        for (int it = 0; it < 60; it++) begin
            for (int m = 0; m < 2; m++) if (!p_req[m] && $urandom_range(0, 1) == 1) rand_post(m);
            if (!p_req[0] && !p_req[1]) rand_post(int'($urandom_range(0, 1)));
            arbitrate_once(rd, er);
        end
        for (int k = 0; k < 2; k++) if (p_req[0] || p_req[1]) arbitrate_once(rd, er);
        for (int i = 128; i < 148; i++) begin
            n_checks++; if (dmem[i] !== ref_mem[i]) begin n_errors++; $display("FAIL random_mem[%0d]: got %h want %h", i, dmem[i], ref_mem[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_subword();
        test_errors();
        test_tie();
        test_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
